dst40_sbox_bank: RTL and testbench
==================================

Name: dst40_sbox_bank

Overview:
Multi-channel, pipelined, runtime-programmable 4-to-2 S-box evaluator for the DST40 core. It replaces per-instance combinational Fh lookups with CH parallel lanes behind a two-stage valid/ready pipeline. It also holds NTBL loadable tables, so Fg, Fh or test mappings can share one engine. Every table resets to the Fh mapping.

Parameters:
CH, 4, number of parallel 4-bit lanes per beat
NTBL, 2, number of independently loadable 16x2 tables (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  4*CH  lane k nibble at [4k+3:4k]
in_sel  in  SW  table index for the whole beat; SW = max(1,$clog2(NTBL))
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  2*CH  lane k result at [2k+1:2k]
tbl_we  in  1  table write strobe
tbl_idx  in  SW  table to write
tbl_addr  in  4  entry address
tbl_data  in  2  entry value
busy  out  1  s1_valid || s2_valid

Behaviour:
- Reset value of every table entry (all NTBL tables), addr 0..F: 0,0,2,3,3,1,2,1,1,2,1,3,3,2,0,0.
- Outputs on reset: in_ready=1, out_valid=0, out_data=0, busy=0. s1/s2 valids clear. Table contents return to the default mapping.
- Stage S1 registers in_data and in_sel on accept.
- Stage S2 registers the CH lookups of S1 data in table S1.sel when S1 advances.
- out_data/out_valid are driven directly from S2 registers. Latency is 2 cycles from accept to out_valid with no backpressure.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_adv, purely combinational from state and out_ready
  - Full throughput: 1 beat/cycle when out_ready=1.
  - Capacity is 2 beats. No skid buffer.
- out_data holds stable while out_valid && !out_ready. S2 clears out_valid when it emits without refill.
- in_sel >= NTBL: the lookup result is 0 on all lanes, and the beat still flows normally.
- Table writes:
  - Accepted every cycle regardless of pipeline state.
  - Visible to lookups performed on the following edge onward.
  - A lookup performed on the same edge as a write to the same entry uses the old value.
  - tbl_idx >= NTBL: the write is ignored.
- Writes to one table never affect other tables. A beat already in S2 is never altered by a later write.
- Simultaneous S2 emit and S1→S2 advance in the same cycle: S2 loads the new result, and out_valid stays 1.
- Reset asserted mid-operation: in-flight beats are discarded immediately (asynchronous) and no partial output appears. After deassertion the first accepted beat sees default tables.

Decomposition:
- Shared package dst40_pkg:
  - FH_DEFAULT, a 16x2 constant with the values above
  - localparams NIB_W=4 and SB_W=2
  - function for SW
- One sub-module: dst40_sbox_tbl, a single 16x2 table with async reset to FH_DEFAULT, registered write, and CH combinational read ports.
- dst40_sbox_bank instantiates NTBL copies and muxes the results by S1.sel.

Test Plan:
1. After reset, sel=0, in_data=0x3210, out_ready=1 -> out_data=0xE0 exactly 2 cycles later. Then in_data=0xFEDC -> 0x0B on the next cycle (back-to-back throughput).
2. Write tbl_idx=1, addr=0, data=3. Next cycle send 0x0000 with sel=1 -> 0xFF. Send 0x0000 with sel=0 -> 0x00 (table isolation).
3. Write addr 2 of table 0 to 0 in the same cycle S1 holds 0x2222 (sel 0) advancing -> out 0xAA (old value). The next 0x2222 beat -> 0x00.
4. Hold out_ready=0 and present 3 beats -> beats 1 and 2 are accepted and in_ready=0 from cycle 2. out_data stays stable. Raise out_ready -> beats are emitted in order with no loss or duplication.
5. Send sel=2 with NTBL=2 -> out_data=0. Write with tbl_idx=3 -> no table changes (read-back via lookups of all 16 addresses).
6. Assert rst_n=0 with both stages full and table 1 modified -> out_valid=0 and busy=0 immediately. After release, 0x3210 sel=1 -> 0xE0.

Source files
------------

// File: rtl/dst40_pkg.sv
// Shared constants and helpers for the DST40 S-box engine.
package dst40_pkg;

  localparam int NIB_W = 4;
  localparam int SB_W  = 2;

  // Fh mapping; element [a] is the output for input nibble a.
  // Listed from address 15 down to 0.
  localparam logic [15:0][SB_W-1:0] FH_DEFAULT = {
    2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1,
    2'd1, 2'd2, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0
  };

  // Width of a table selector; never less than one bit.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dst40_sbox_tbl.sv
// One loadable 16x2 S-box table with CH combinational read ports.
module dst40_sbox_tbl
  import dst40_pkg::*;
#(
  parameter int CH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [NIB_W-1:0]      i_addr,
  input  logic [SB_W-1:0]       i_data,
  input  logic [NIB_W*CH-1:0]   i_rd_addr,
  output logic [SB_W*CH-1:0]    o_rd_data
);

  logic [15:0][SB_W-1:0] r_mem;

  // Table storage: reset to Fh, single registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_mem <= FH_DEFAULT;
    else if (i_we) r_mem[i_addr] <= i_data;
  end

  // Reads see the pre-edge contents, so a same-edge write is not yet visible.
  for (genvar k = 0; k < CH; k++) begin : g_rd
    assign o_rd_data[SB_W*k +: SB_W] = r_mem[i_rd_addr[NIB_W*k +: NIB_W]];
  end

endmodule

// File: rtl/dst40_sbox_bank.sv
// CH-lane, two-stage valid/ready S-box evaluator over NTBL loadable tables.
module dst40_sbox_bank
  import dst40_pkg::*;
#(
  parameter int CH   = 4,
  parameter int NTBL = 2,
  parameter int SW   = sel_w(NTBL)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIB_W*CH-1:0]  in_data,
  input  logic [SW-1:0]        in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SB_W*CH-1:0]   out_data,
  input  logic                 tbl_we,
  input  logic [SW-1:0]        tbl_idx,
  input  logic [NIB_W-1:0]     tbl_addr,
  input  logic [SB_W-1:0]      tbl_data,
  output logic                 busy
);

  // Bit 1 = S1 holds a beat, bit 2 = S2 holds a result.
  logic [2:1]                   r_vld_pipe;
  logic [NIB_W*CH-1:0]          r_s1_data;
  logic [SW-1:0]                r_s1_sel;
  logic [SB_W*CH-1:0]           r_s2_data;

  logic                         w_s2_adv;
  logic [NTBL-1:0]              w_we;
  logic [NTBL-1:0][SB_W*CH-1:0] w_rd;
  logic [SB_W*CH-1:0]           w_lut;

  assign w_s2_adv  = r_vld_pipe[1] && (!r_vld_pipe[2] || out_ready);
  assign in_ready  = !r_vld_pipe[1] || w_s2_adv;
  assign out_valid = r_vld_pipe[2];
  assign out_data  = r_s2_data;
  assign busy      = |r_vld_pipe;

  // Out-of-range tbl_idx matches no table, so the write is dropped.
  for (genvar t = 0; t < NTBL; t++) begin : g_tbl
    assign w_we[t] = tbl_we && (tbl_idx == SW'(t));
    dst40_sbox_tbl #(.CH(CH)) u_tbl (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we[t]),
      .i_addr    (tbl_addr),
      .i_data    (tbl_data),
      .i_rd_addr (r_s1_data),
      .o_rd_data (w_rd[t])
    );
  end

  // Select the S1 beat's table; an unknown selector yields all-zero lanes.
  always_comb begin
    w_lut = '0;
    for (int t = 0; t < NTBL; t++)
      if (r_s1_sel == SW'(t)) w_lut = w_rd[t];
  end

  // Pipeline registers: S1 captures input beats, S2 captures lookup results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_data  <= '0;
      r_s1_sel   <= '0;
      r_s2_data  <= '0;
    end else begin
      if (in_ready) begin
        r_vld_pipe[1] <= in_valid;
        if (in_valid) begin
          r_s1_data <= in_data;
          r_s1_sel  <= in_sel;
        end
      end
      if (w_s2_adv) begin
        r_vld_pipe[2] <= 1'b1;
        r_s2_data     <= w_lut;
      end else if (out_ready) begin
        r_vld_pipe[2] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dst40_sbox_bank.sv
// Self-checking bench for dst40_sbox_bank: cycle model plus directed literals.
module tb_dst40_sbox_bank;
  localparam int CH   = 4;
  localparam int NTBL = 3;
  localparam int SW   = 2;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
  logic [4*CH-1:0] in_data = '0;
  logic [SW-1:0]   in_sel = '0;
  logic [2*CH-1:0] out_data;
  logic            tbl_we = 0;
  logic [SW-1:0]   tbl_idx = '0;
  logic [3:0]      tbl_addr = '0;
  logic [1:0]      tbl_data = '0;

  int errors = 0, checks = 0;

  dst40_sbox_bank #(.CH(CH), .NTBL(NTBL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .tbl_we(tbl_we),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int fh [16] = '{0,0,2,3,3,1,2,1,1,2,1,3,3,2,0,0};
  int m_tbl [NTBL][16];
  bit m1v, m2v;
  logic [4*CH-1:0] m1d;
  int              m1s;
  logic [2*CH-1:0] m2d;

  function automatic logic [2*CH-1:0] lookup(input logic [4*CH-1:0] d, input int s);
    logic [2*CH-1:0] r = '0;
    if (s < NTBL)
      for (int k = 0; k < CH; k++) r[2*k +: 2] = 2'(m_tbl[s][d[4*k +: 4]]);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1v = 0; m2v = 0; m1d = '0; m1s = 0; m2d = '0;
      for (int t = 0; t < NTBL; t++) for (int a = 0; a < 16; a++) m_tbl[t][a] = fh[a];
    end else begin
      bit adv, rdy;
      adv = m1v && (!m2v || out_ready);
      rdy = !m1v || adv;
      if (adv) begin m2v = 1; m2d = lookup(m1d, m1s); end
      else if (out_ready) m2v = 0;
      if (rdy) begin
        m1v = in_valid;
        if (in_valid) begin m1d = in_data; m1s = int'(in_sel); end
      end
      if (tbl_we && int'(tbl_idx) < NTBL) m_tbl[tbl_idx][tbl_addr] = int'(tbl_data);
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) if (rst_n) begin
    chk("in_ready", 32'(in_ready), 32'(!m1v || (!m2v || out_ready)));
    chk("out_valid", 32'(out_valid), 32'(m2v));
    chk("busy", 32'(busy), 32'(m1v || m2v));
    if (m2v) chk("out_data", 32'(out_data), 32'(m2d));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [SW-1:0] s);
    in_valid = 1; in_data = d; in_sel = s;
    step();
    in_valid = 0;
  endtask

  logic [2*CH-1:0] held;

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    step(); step();
    rst_n = 1;
    step();

    // 1: latency and back-to-back
    send(16'h3210, 0);
    in_valid = 1; in_data = 16'hFEDC; in_sel = 0;
    step();
    in_valid = 0;
    chk("t1_first", 32'(out_data), 32'hE0);
    chk("t1_first_vld", 32'(out_valid), 1);
    step();
    chk("t1_second", 32'(out_data), 32'h0B);
    step();

    // 2: table isolation
    tbl_we = 1; tbl_idx = 1; tbl_addr = 0; tbl_data = 3;
    step();
    tbl_we = 0;
    send(16'h0000, 1);
    send(16'h0000, 0);
    chk("t2_sel1", 32'(out_data), 32'hFF);
    step();
    chk("t2_sel0", 32'(out_data), 32'h00);
    step();

    // 3: same-edge write uses old value
    send(16'h2222, 0);
    tbl_we = 1; tbl_idx = 0; tbl_addr = 2; tbl_data = 0;
    step();
    tbl_we = 0;
    chk("t3_old", 32'(out_data), 32'hAA);
    send(16'h2222, 0);
    step();
    chk("t3_new", 32'(out_data), 32'h00);
    step();

    // 4: backpressure, capacity 2
    out_ready = 0;
    in_valid = 1; in_data = 16'h1357; in_sel = 0;
    step();
    in_data = 16'h9BDF; in_sel = 1;
    step();
    chk("t4_full_rdy", 32'(in_ready), 0);
    in_data = 16'h4567; in_sel = 2;
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_hold", 32'(out_data), 32'(held));
      chk("t4_hold_rdy", 32'(in_ready), 0);
    end
    out_ready = 1;
    step();
    in_valid = 0;
    repeat (4) step();

    // 5: invalid selector and ignored writes
    send(16'hFFFF, 3);
    step();
    chk("t5_badsel", 32'(out_data), 0);
    for (int a = 0; a < 16; a++) begin
      tbl_we = 1; tbl_idx = 3; tbl_addr = 4'(a); tbl_data = 2'(~fh[a]);
      step();
    end
    tbl_we = 0;
    for (int t = 0; t < NTBL; t++)
      for (int g = 0; g < 4; g++)
        send({4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)}, SW'(t));
    send(16'h3210, 2);
    step();
    chk("t5_tbl2", 32'(out_data), 32'hE0);
    step();

    // 6: async reset mid-flight
    tbl_we = 1; tbl_idx = 1; tbl_addr = 1; tbl_data = 3;
    step();
    tbl_we = 0;
    out_ready = 0;
    send(16'h3210, 1);
    send(16'h3210, 1);
    chk("t6_busy_pre", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    step(); step();
    rst_n = 1;
    out_ready = 1;
    step();
    send(16'h3210, 1);
    step();
    chk("t6_default", 32'(out_data), 32'hE0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      in_sel    = SW'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      tbl_we    = ($urandom_range(0, 7) == 0);
      tbl_idx   = SW'($urandom_range(0, 3));
      tbl_addr  = 4'($urandom);
      tbl_data  = 2'($urandom);
      step();
    end
    in_valid = 0; tbl_we = 0; out_ready = 1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
